// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU in the execute stage.
// Produces one quotient bit per cycle; result_o = {remainder, quotient}.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_dvs;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_W-1:0]     w_rem_nxt;
  logic [DATA_W-1:0]     w_quo_nxt;
  logic [DATA_W-1:0]     w_dvs_nxt;
  logic                  w_neg_q_nxt;
  logic                  w_neg_r_nxt;
  logic [2*DATA_W-1:0]   w_result_nxt;
  logic                  w_ready_nxt;

  logic [DATA_W:0]       w_shift;
  logic [DATA_W:0]       w_diff;
  logic [DATA_W-1:0]     w_rem_step;
  logic [DATA_W-1:0]     w_quo_step;
  logic                  w_last;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sg);
    magnitude = (sg && v[DATA_W-1]) ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    apply_sign = neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign w_shift    = {r_rem, r_quo[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_rem_step = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_step = {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
  // The final quotient bit and the sign fixup share one edge to keep latency at DATA_W+1.
  assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; annul has priority over start in FREE, BYZERO and ON
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          w_state_nxt = (opdata2_i == {DATA_W{1'b0}}) ? S_BYZERO : S_ON;
        end else begin
          w_state_nxt = S_FREE;
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          w_state_nxt = S_FREE;
        end else begin
          w_state_nxt = S_END;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt = S_FREE;
        end else if (w_last) begin
          w_state_nxt = S_END;
        end else begin
          w_state_nxt = S_ON;
        end
      end
      S_END: begin
        if (start_i) begin
          w_state_nxt = S_END;
        end else begin
          w_state_nxt = S_FREE;
        end
      end
      default: w_state_nxt = S_FREE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvs_nxt    = r_dvs;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_result_nxt = {(2*DATA_W){1'b0}};
    w_ready_nxt  = 1'b0;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i && (opdata2_i != {DATA_W{1'b0}})) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_rem_nxt   = {DATA_W{1'b0}};
          w_quo_nxt   = magnitude(opdata1_i, signed_div_i);
          w_dvs_nxt   = magnitude(opdata2_i, signed_div_i);
          w_neg_q_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          w_neg_r_nxt = signed_div_i & opdata1_i[DATA_W-1];
        end else begin
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          w_ready_nxt = 1'b0;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_rem_nxt = w_rem_step;
          w_quo_nxt = w_quo_step;
          if (w_last) begin
            w_result_nxt = {apply_sign(w_rem_step, r_neg_r), apply_sign(w_quo_step, r_neg_q)};
            w_ready_nxt  = 1'b1;
          end else begin
            w_ready_nxt  = 1'b0;
          end
        end
      end
      S_END: begin
        if (start_i) begin
          w_result_nxt = r_result;
          w_ready_nxt  = 1'b1;
        end else begin
          w_ready_nxt  = 1'b0;
        end
      end
      default: begin
        w_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_rem    <= {DATA_W{1'b0}};
      r_quo    <= {DATA_W{1'b0}};
      r_dvs    <= {DATA_W{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= {(2*DATA_W){1'b0}};
      r_ready  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvs    <= w_dvs_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases from the plan plus random
// operands checked against a plain-arithmetic division model.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks;
  int failures;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division, remainder follows dividend sign, x/0 -> 0.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] qv;
    logic [63:0] rv;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a division with start held; returns the edge count at which ready_o first appears (0 = timeout).
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output int lat, output logic [63:0] res);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    res          = 64'd0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (ready_o === 1'b1) begin
        lat = e;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    tick(); tick();
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    checks++;
    if (result_o !== 64'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_basic();
    int lat;
    logic [63:0] res;
    do_div(1'b0, 32'd100, 32'd7, 1'b0, lat, res);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL u100_7_latency got=%0d want=33", lat); end
    checks++;
    if (res !== {32'h2, 32'hE}) begin failures++; $display("FAIL u100_7_result got=%h want=%h", res, {32'h2, 32'hE}); end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ready_o !== 1'b1 || result_o !== {32'h2, 32'hE}) begin
      failures++; $display("FAIL u100_7_hold got=%b/%h want=1/%h", ready_o, result_o, {32'h2, 32'hE});
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++; $display("FAIL u100_7_drop got=%b/%h want=0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [63:0] res;
    do_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0, lat, res);
    checks++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || lat !== 33) begin
      failures++; $display("FAIL s_m7_2 got=%h lat=%0d want=ffffffff_fffffffd lat=33", res, lat);
    end
    start_i = 1'b0; tick();
    do_div(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0, lat, res);
    checks++;
    if (res !== {32'h1, 32'hFFFFFFFD} || lat !== 33) begin
      failures++; $display("FAIL s_7_m2 got=%h lat=%0d want=00000001_fffffffd lat=33", res, lat);
    end
    start_i = 1'b0; tick();
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res);
    checks++;
    if (res !== {32'h0, 32'h80000000} || lat !== 33) begin
      failures++; $display("FAIL s_overflow got=%h lat=%0d want=00000000_80000000 lat=33", res, lat);
    end
    start_i = 1'b0; tick();
    do_div(1'b0, 32'h0, 32'h1234, 1'b0, lat, res);
    checks++;
    if (res !== 64'd0 || lat !== 33) begin
      failures++; $display("FAIL zero_dividend got=%h lat=%0d want=0 lat=33", res, lat);
    end
    start_i = 1'b0; tick();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] res;
    for (int m = 0; m < 2; m++) begin
      do_div(1'(m), 32'h12345678, 32'h0, 1'b0, lat, res);
      checks++;
      if (lat !== 2 || res !== 64'd0) begin
        failures++; $display("FAIL div0_mode%0d got lat=%0d res=%h want lat=2 res=0", m, lat, res);
      end
      tick(); tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== 64'd0) begin
        failures++; $display("FAIL div0_hold_mode%0d got=%b/%h want=1/0", m, ready_o, result_o);
      end
      start_i = 1'b0; tick();
      checks++;
      if (ready_o !== 1'b0) begin failures++; $display("FAIL div0_drop_mode%0d got=%b want=0", m, ready_o); end
    end
  endtask

  task automatic test_annul();
    int lat;
    int seen;
    logic [63:0] res;
    signed_div_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'h3; start_i = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL annul_no_ready got=%0d ready cycles want=0", seen); end
    do_div(1'b0, 32'hFFFFFFFF, 32'h10, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== {32'hF, 32'h0FFFFFFF}) begin
      failures++; $display("FAIL after_annul got lat=%0d res=%h want lat=33 res=0000000f_0fffffff", lat, res);
    end
    start_i = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] res;
    signed_div_i = 1'b0; opdata1_i = 32'hCAFEF00D; opdata2_i = 32'h5; start_i = 1'b1;
    tick();
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      failures++; $display("FAIL reset_mid got=%b/%h want=0/0", ready_o, result_o);
    end
    rst = 1'b0; start_i = 1'b0;
    tick();
    do_div(1'b0, 32'd9, 32'd3, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== {32'h0, 32'h3}) begin
      failures++; $display("FAIL after_reset_9_3 got lat=%0d res=%h want lat=33 res=0_3", lat, res);
    end
    start_i = 1'b0; tick();
  endtask

  task automatic test_random();
    int lat;
    int want_lat;
    logic [63:0] res;
    logic [63:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    for (int n = 0; n < 24; n++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      exp      = ref_div(sg, a, b);
      want_lat = (b == 32'd0) ? 2 : 33;
      do_div(sg, a, b, 1'b1, lat, res);
      checks++;
      if (lat !== want_lat || res !== exp) begin
        failures++;
        $display("FAIL random_%0d sg=%b a=%h b=%h got lat=%0d res=%h want lat=%0d res=%h",
                 n, sg, a, b, lat, res, want_lat, exp);
      end
      start_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] res;
    do_div(1'b0, 32'd50, 32'd5, 1'b0, lat, res);
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (ready_o !== 1'b1 || result_o !== {32'h0, 32'hA}) begin
      failures++; $display("FAIL b2b_held_end got=%b/%h want=1/0_a", ready_o, result_o);
    end
    start_i = 1'b0; tick();
    do_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== ref_div(1'b1, 32'hFFFFFF9C, 32'd7)) begin
      failures++; $display("FAIL b2b_second got lat=%0d res=%h want lat=33 res=%h", lat, res, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));
    end
    start_i = 1'b0; tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
